// File: rtl/bext_issue_ctrl.sv
// rtl/bext_issue_ctrl.sv - B-extension issue/sequencing controller
// Registers one request, runs one compute cycle (or CLMUL_CYCLES for clmul), holds the result.
module bext_issue_ctrl #(
    parameter int WIDTH        = 64,
    parameter int CLMUL_CYCLES = 2,
    parameter int TAG_W        = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [WIDTH-1:0] req_operand_a_i,
    input  logic [WIDTH-1:0] req_operand_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_result_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_illegal_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, CLMUL, RESP} state_e;

    state_e             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [2:0]         cnt_q;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   rtag_q;
    logic               illegal_q, illegal_d;
    logic [2*WIDTH-1:0] prod;
    logic               accept;
    logic               req_is_clmul;

    function automatic logic [6:0] popcnt(input logic [WIDTH-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + 7'(v[i]);
        return c;
    endfunction

    // w selects full-width (64) or word (32) counting of the low w bits
    function automatic logic [6:0] lzc(input logic [WIDTH-1:0] v, input int w);
        logic [6:0] n;
        n = 7'(w);
        for (int i = 0; i < WIDTH; i++)
            if (i < w && v[i]) n = 7'(w - 1 - i);
        return n;
    endfunction

    function automatic logic [6:0] tzc(input logic [WIDTH-1:0] v, input int w);
        logic [6:0] n;
        n = 7'(w);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (i < w && v[i]) n = 7'(i);
        return n;
    endfunction

    function automatic logic [2*WIDTH-1:0] clmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) p = p ^ ({{WIDTH{1'b0}}, a} << i);
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] xperm8(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [7:0]       idx;
        r = '0;
        for (int i = 0; i < WIDTH / 8; i++) begin
            idx = b[8*i +: 8];
            if (idx < 8'd8) r[8*i +: 8] = a[{idx[2:0], 3'b000} +: 8];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] xperm4(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [3:0]       idx;
        r = '0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            idx = b[4*i +: 4];
            r[4*i +: 4] = a[{idx, 2'b00} +: 4];
        end
        return r;
    endfunction

    assign prod = clmul(a_q, b_q);

    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
        case (op_q)
            4'd0:    result_d = WIDTH'(popcnt(a_q));
            4'd1:    result_d = WIDTH'(popcnt({{(WIDTH-32){1'b0}}, a_q[31:0]}));
            4'd2:    result_d = WIDTH'(lzc(a_q, WIDTH));
            4'd3:    result_d = WIDTH'(lzc(a_q, 32));
            4'd4:    result_d = WIDTH'(tzc(a_q, WIDTH));
            4'd5:    result_d = WIDTH'(tzc(a_q, 32));
            4'd6:    result_d = prod[WIDTH-1:0];
            4'd7:    result_d = prod[2*WIDTH-1:WIDTH];
            4'd8:    result_d = prod[2*WIDTH-2:WIDTH-1];
            4'd9:    result_d = xperm8(a_q, b_q);
            4'd10:   result_d = xperm4(a_q, b_q);
            default: illegal_d = 1'b1;
        endcase
    end

    // Ready follows resp_ready_i combinationally so RESP can hand straight over to a new request
    assign req_ready_o   = !flush_i && (state_q == IDLE || (state_q == RESP && resp_ready_i));
    assign accept        = req_valid_i && req_ready_o;
    assign req_is_clmul  = (req_op_i >= 4'd6) && (req_op_i <= 4'd8);

    assign resp_valid_o   = (state_q == RESP);
    assign busy_o         = (state_q != IDLE);
    assign resp_result_o  = result_q;
    assign resp_tag_o     = rtag_q;
    assign resp_illegal_o = illegal_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            rtag_q    <= '0;
            illegal_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            if (accept) begin
                op_q    <= req_op_i;
                a_q     <= req_operand_a_i;
                b_q     <= req_operand_b_i;
                tag_q   <= req_tag_i;
                state_q <= req_is_clmul ? CLMUL : EXEC;
                if (req_is_clmul) cnt_q <= 3'(CLMUL_CYCLES - 1);
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    EXEC: begin
                        result_q  <= result_d;
                        illegal_q <= illegal_d;
                        rtag_q    <= tag_q;
                        state_q   <= RESP;
                    end
                    CLMUL: begin
                        if (cnt_q == 3'd0) begin
                            result_q  <= result_d;
                            illegal_q <= illegal_d;
                            rtag_q    <= tag_q;
                            state_q   <= RESP;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                    RESP: if (resp_ready_i) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bext_issue_ctrl.sv
// tb/tb_bext_issue_ctrl.sv - randomized self-checking bench for bext_issue_ctrl
// Reference results are computed bit-by-bit from the Zbb/Zbc/Zbkx definitions.
module tb_bext_issue_ctrl;

    localparam int CC = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = '0;
    logic [63:0] req_operand_a_i = '0;
    logic [63:0] req_operand_b_i = '0;
    logic [4:0]  req_tag_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [63:0] resp_result_o;
    logic [4:0]  resp_tag_o;
    logic        resp_illegal_o;
    logic        busy_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bext_issue_ctrl #(.WIDTH(64), .CLMUL_CYCLES(CC), .TAG_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i), .req_tag_i(req_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_result_o(resp_result_o),
        .resp_tag_o(resp_tag_o), .resp_illegal_o(resp_illegal_o), .busy_o(busy_o)
    );

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {illegal, result}
    function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  v;
        logic [127:0] p;
        logic [63:0]  r;
        int           n;
        int           idx;
        r = '0;
        case (op)
            4'd0: r = 64'($countones(a));
            4'd1: r = 64'($countones(a[31:0]));
            4'd2: begin n = 0; v = a; while (n < 64 && !v[63]) begin v = v << 1; n++; end r = 64'(n); end
            4'd3: begin n = 0; v = {a[31:0], 32'h0}; while (n < 32 && !v[63]) begin v = v << 1; n++; end r = 64'(n); end
            4'd4: begin n = 0; v = a; while (n < 64 && !v[0]) begin v = v >> 1; n++; end r = 64'(n); end
            4'd5: begin n = 0; v = {32'h0, a[31:0]}; while (n < 32 && !v[0]) begin v = v >> 1; n++; end r = 64'(n); end
            4'd6, 4'd7, 4'd8: begin
                p = '0;
                for (int k = 0; k < 127; k++)
                    for (int i = 0; i < 64; i++)
                        if (k - i >= 0 && k - i < 64) p[k] = p[k] ^ (a[i] & b[k-i]);
                if (op == 4'd6) r = p[63:0];
                else if (op == 4'd7) r = p[127:64];
                else r = p[126:63];
            end
            4'd9: for (int i = 0; i < 8; i++) begin
                idx = int'((b >> (8*i)) & 64'hFF);
                if (idx < 8) r = r | (((a >> (8*idx)) & 64'hFF) << (8*i));
            end
            4'd10: for (int i = 0; i < 16; i++) begin
                idx = int'((b >> (4*i)) & 64'hF);
                r = r | (((a >> (4*idx)) & 64'hF) << (4*i));
            end
            default: return {1'b1, 64'h0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (op >= 4'd6 && op <= 4'd8) ? 1 + CC : 2;
    endfunction

    task automatic drive_req(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_operand_a_i = a;
        req_operand_b_i = b;
        req_tag_i = tag;
    endtask

    // Entered at the negedge one cycle after the accepting edge; leaves the response pending
    task automatic wait_resp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        logic [64:0] e;
        int off;
        e = ref_op(op, a, b);
        off = 1;
        while (!resp_valid_o && off < 30) begin
            expect_eq("busy_compute", busy_o, 1);
            @(negedge clk);
            off++;
        end
        expect_eq($sformatf("latency op%0d", op), off, exp_lat(op));
        expect_eq($sformatf("result op%0d a=%h b=%h", op, a, b), resp_result_o, e[63:0]);
        expect_eq("tag", resp_tag_o, tag);
        expect_eq($sformatf("illegal op%0d", op), resp_illegal_o, e[64]);
        expect_eq("busy_resp", busy_o, 1);
    endtask

    task automatic consume();
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        expect_eq("valid_after_consume", resp_valid_o, 0);
        expect_eq("busy_after_consume", busy_o, 0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        drive_req(op, a, b, tag);
        #1;
        expect_eq("req_ready_idle", req_ready_o, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_operand_a_i = ~a;
        req_operand_b_i = ~b;
        wait_resp(op, a, b, tag);
        consume();
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = 64'h1 << $urandom_range(0, 63);
            2: v = {v[63:32], 32'h0};
            3: v = v & 64'h0F0F_0F0F_0F0F_0F0F;
            default: ;
        endcase
        return v;
    endfunction

    logic [63:0] hold_res;
    logic [4:0]  hold_tag;
    logic        hold_ill;

    initial begin
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        expect_eq("rst_valid", resp_valid_o, 0);
        expect_eq("rst_busy", busy_o, 0);
        expect_eq("rst_result", resp_result_o, 0);
        expect_eq("rst_tag", resp_tag_o, 0);
        expect_eq("rst_illegal", resp_illegal_o, 0);
        expect_eq("rst_req_ready", req_ready_o, 1);

        run_op(4'd0, 64'hFFFF_0000_0000_00FF, 64'h0, 5'd3);
        run_op(4'd3, 64'h0000_0001_0000_0000, 64'h0, 5'd4);
        run_op(4'd4, 64'h0, 64'h0, 5'd5);
        run_op(4'd2, 64'h0000_8000_0000_0000, 64'h0, 5'd6);
        run_op(4'd2, 64'h0, 64'h0, 5'd7);
        run_op(4'd5, 64'hFFFF_FFFF_0000_0000, 64'h0, 5'd8);
        run_op(4'd1, 64'hFFFF_FFFF_0000_000F, 64'h0, 5'd9);
        run_op(4'd6, '1, '1, 5'd10);
        run_op(4'd7, '1, '1, 5'd11);
        run_op(4'd8, '1, '1, 5'd12);
        run_op(4'd9, 64'h0706050403020100, 64'h0001020308FF0706, 5'd13);
        run_op(4'd10, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 5'd14);
        run_op(4'd12, 64'h1234, 64'h5678, 5'd15);

        for (int i = 0; i < 60; i++)
            run_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));

        // Stalled response, then consume and accept in the same cycle
        drive_req(4'd0, 64'hFF, 64'h0, 5'd21);
        @(negedge clk);
        drive_req(4'd6, 64'h3, 64'h3, 5'd22);
        wait_resp(4'd0, 64'hFF, 64'h0, 5'd21);
        hold_res = resp_result_o;
        hold_tag = resp_tag_o;
        hold_ill = resp_illegal_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            expect_eq("stall_valid", resp_valid_o, 1);
            expect_eq("stall_result", resp_result_o, hold_res);
            expect_eq("stall_tag", resp_tag_o, hold_tag);
            expect_eq("stall_illegal", resp_illegal_o, hold_ill);
            expect_eq("stall_req_ready", req_ready_o, 0);
        end
        resp_ready_i = 1'b1;
        #1;
        expect_eq("b2b_req_ready", req_ready_o, 1);
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        expect_eq("b2b_valid_gap", resp_valid_o, 0);
        wait_resp(4'd6, 64'h3, 64'h3, 5'd22);
        consume();

        // Flush during the second clmul cycle
        drive_req(4'd7, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_FFFF_0000, 5'd23);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        expect_eq("flush_req_ready", req_ready_o, 0);
        @(negedge clk);
        flush_i = 1'b0;
        expect_eq("flush_busy", busy_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_eq("flush_no_valid", resp_valid_o, 0);
        end

        // Flush in RESP with ready and a competing request
        drive_req(4'd0, 64'h7, 64'h0, 5'd24);
        @(negedge clk);
        req_valid_i = 1'b0;
        wait_resp(4'd0, 64'h7, 64'h0, 5'd24);
        flush_i = 1'b1;
        resp_ready_i = 1'b1;
        drive_req(4'd2, 64'h1, 64'h0, 5'd25);
        #1;
        expect_eq("flush_resp_req_ready", req_ready_o, 0);
        @(negedge clk);
        flush_i = 1'b0;
        resp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        expect_eq("flush_resp_valid", resp_valid_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_eq("flush_resp_no_accept", busy_o, 0);
        end

        // Reset mid-countdown
        drive_req(4'd8, 64'hAAAA, 64'h5555, 5'd26);
        @(negedge clk);
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        expect_eq("midrst_valid", resp_valid_o, 0);
        expect_eq("midrst_busy", busy_o, 0);
        expect_eq("midrst_result", resp_result_o, 0);
        expect_eq("midrst_tag", resp_tag_o, 0);
        expect_eq("midrst_illegal", resp_illegal_o, 0);
        expect_eq("midrst_req_ready", req_ready_o, 1);
        run_op(4'd0, 64'h0, 64'h0, 5'd27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
